mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single memory port between the core datapath (IF fetch, load/store)
//   and a host/debug port (program load, memory inspection).
//   Each side issues one access at a time with a req/done handshake.
//   Simultaneous requests are resolved round-robin.
//   core_busy tells phasegen to hold the current phase until the core access completes.
// PARAMETERS
//   MEM_LAT  2  memory access cycles per transfer (>=1); mem_* strobes held this long
// PORTS
//   clock        in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   core_req     in   1   core access request; level, held until core_done
//   core_we      in   1   1=store, 0=read (fetch/load)
//   core_addr    in   32  core byte address
//   core_wrbits  in   4   core byte-lane write mask
//   core_wdata   in   32  core store data
//   core_rdata   out  32  read data; valid while core_done=1
//   core_done    out  1   one-cycle completion pulse to core
//   core_busy    out  1   core_req && !core_done; phasegen stall
//   host_req     in   1   host access request; level, held until host_done
//   host_we      in   1   1=write, 0=read
//   host_addr    in   32  host byte address
//   host_wrbits  in   4   host byte-lane write mask
//   host_wdata   in   32  host write data
//   host_rdata   out  32  read data; valid while host_done=1
//   host_done    out  1   one-cycle completion pulse to host
//   mem_addr     out  32  memory address (latched request)
//   mem_read     out  1   memory read strobe
//   mem_write    out  1   memory write strobe
//   mem_wrbits   out  4   memory byte-lane mask; 4'b0000 when mem_write=0
//   mem_wdata    out  32  memory write data
//   mem_rdata    in   32  memory read data; valid in the last ACCESS cycle
// BEHAVIOUR
//   Reset:
//     - state=IDLE; all outputs 0; last_grant=HOST, so core wins the first tie.
//     - Reset mid-ACCESS drops the strobes immediately and discards the transfer; no done is issued.
//   FSM IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE:
//     - Sample req lines. One requester: grant it.
//     - Both requesting: grant the side != last_grant.
//     - On grant: latch owner/we/addr/wrbits/wdata, cnt=MEM_LAT-1, last_grant=owner, go ACCESS.
//     - No req: stay IDLE.
//   ACCESS:
//     - Drive mem_addr and mem_wdata from the latch.
//     - mem_read=!we, mem_write=we, mem_wrbits=we?wrbits:0.
//     - cnt decrements each cycle. At cnt==0, capture mem_rdata into the owner's rdata reg and go RESP.
//     - Request inputs are ignored here; changing them mid-access has no effect.
//   RESP:
//     - Strobes 0; owner's done=1 for exactly one cycle; go IDLE.
//     - The requester deasserts or renews req at the edge closing RESP, so IDLE never regrants a stale request.
//   Latency: req seen in IDLE at cycle 0 -> strobes in cycles 1..MEM_LAT -> done in cycle MEM_LAT+1.
//     Back-to-back throughput is 1 transfer per MEM_LAT+2 cycles.
//   rdata regs:
//     - Hold their value until the next read completes for that side.
//     - Writes leave rdata unchanged.
//   Non-owner: its req stays pending; no done, and its busy stays 1.
//   core_busy is combinational: core_req & ~core_done.
//   Widths: no arithmetic on addresses; cnt is $clog2(MEM_LAT+1) bits and never wraps below 0.
// TESTING
//   T1 core read, MEM_LAT=2, addr=0x100, mem_rdata=0xDEADBEEF:
//      mem_read in cycles 1-2 -> core_done in cycle 3 with core_rdata=0xDEADBEEF.
//   T2 host write, addr=0x8, wrbits=4'b0011, wdata=0x1234:
//      mem_write=1 and mem_wrbits=0011 for 2 cycles -> host_done at cycle 3; core_rdata unchanged.
//   T3 both req at cycle 0 after reset -> core granted first, host granted in the following IDLE.
//      A second tie grants host (round-robin).
//   T4 core_req held continuously with host idle, 3 reads ->
//      core_done at cycles 3, 7 and 11; core_busy=1 except in done cycles.
//   T5 reset asserted during ACCESS:
//      mem_read/mem_write fall asynchronously, no done is issued.
//      After release, state=IDLE; a new core_req completes normally.
//   T6 host_we toggled and host_addr changed mid-ACCESS -> memory sees only the latched values.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter sharing one fixed-latency memory port.
// Each client holds a level req until a one-cycle done; reads return through per-side rdata regs.
module mem_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [3:0]  core_wrbits,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_done,
  output logic        core_busy,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [3:0]  host_wrbits,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_done,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wrbits,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nx;
  logic        own_host;
  logic        last_host;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [3:0]  lat_wrbits;
  logic [31:0] lat_wdata;
  logic [CW-1:0] cnt;
  logic        grant_core, grant_host;

  // On a tie the side that did not win last time gets the port.
  always_comb begin
    grant_core = 1'b0;
    grant_host = 1'b0;
    if (core_req && host_req) begin
      grant_core = last_host;
      grant_host = ~last_host;
    end else begin
      grant_core = core_req;
      grant_host = host_req;
    end
    state_nx = state;
    case (state)
      IDLE:    if (grant_core || grant_host) state_nx = ACCESS;
      ACCESS:  if (cnt == '0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      own_host   <= 1'b0;
      last_host  <= 1'b1;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wrbits <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      core_rdata <= '0;
      host_rdata <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (grant_core || grant_host) begin
            own_host   <= grant_host;
            last_host  <= grant_host;
            lat_we     <= grant_host ? host_we     : core_we;
            lat_addr   <= grant_host ? host_addr   : core_addr;
            lat_wrbits <= grant_host ? host_wrbits : core_wrbits;
            lat_wdata  <= grant_host ? host_wdata  : core_wdata;
            cnt        <= CW'(MEM_LAT - 1);
          end
        end
        ACCESS: begin
          // cnt parks at zero on the final access cycle rather than wrapping.
          if (cnt == '0) begin
            if (!lat_we) begin
              if (own_host) host_rdata <= mem_rdata;
              else          core_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = lat_addr;
  assign mem_wdata  = lat_wdata;
  assign mem_read   = (state == ACCESS) && !lat_we;
  assign mem_write  = (state == ACCESS) && lat_we;
  assign mem_wrbits = mem_write ? lat_wrbits : 4'b0000;
  assign core_done  = (state == RESP) && !own_host;
  assign host_done  = (state == RESP) && own_host;
  assign core_busy  = core_req & ~core_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: a word memory model answers the port and
// a monitor checks strobes, grant order, latency and returned data per transfer.
module tb_mem_arbiter;
  localparam int MEM_LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [3:0]  core_wrbits = '0;
  logic [31:0] core_rdata;
  logic        core_done, core_busy;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [31:0] host_addr = '0, host_wdata = '0;
  logic [3:0]  host_wrbits = '0;
  logic [31:0] host_rdata;
  logic        host_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic [3:0]  mem_wrbits;

  mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wrbits(core_wrbits), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_done(core_done), .core_busy(core_busy),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wrbits(host_wrbits), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_done(host_done),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wrbits(mem_wrbits), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory seen by the DUT, and an independent reference image for expectations.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clock)
    if (mem_write)
      for (int b = 0; b < 4; b++)
        if (mem_wrbits[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

  typedef struct {
    bit          side;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  wrbits;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t sb[$];
  logic [31:0] exp_core_rd = '0;
  logic [31:0] exp_host_rd = '0;

  task automatic push(input bit side, input bit we, input logic [31:0] addr,
                      input logic [3:0] wb, input logic [31:0] wd);
    txn_t t;
    t.side = side; t.we = we; t.addr = addr; t.wrbits = wb; t.wdata = wd;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (wb[b]) ref_mem[addr[9:2]][8*b +: 8] = wd[8*b +: 8];
      t.rdata = side ? exp_host_rd : exp_core_rd;
    end else begin
      t.rdata = ref_mem[addr[9:2]];
      if (side) exp_host_rd = t.rdata; else exp_core_rd = t.rdata;
    end
    sb.push_back(t);
  endtask

  // Monitor: strobes must match the transfer at the head of the scoreboard.
  int strobe_n = 0;
  always @(negedge clock) begin
    if (!reset) begin
      strobe_n = 0;
    end else begin
      if (mem_read || mem_write) begin
        strobe_n++;
        if (sb.size() > 0) begin
          chk("mem_addr",   mem_addr,   sb[0].addr);
          chk("mem_write",  {31'd0, mem_write}, {31'd0, sb[0].we});
          chk("mem_read",   {31'd0, mem_read},  {31'd0, !sb[0].we});
          chk("mem_wrbits", {28'd0, mem_wrbits}, {28'd0, sb[0].we ? sb[0].wrbits : 4'b0000});
          if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
        end
      end
      if (core_done || host_done) begin
        chk("both_done", {31'd0, core_done && host_done}, 32'd0);
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          txn_t e;
          e = sb.pop_front();
          chk("done_side", {31'd0, host_done}, {31'd0, e.side});
          chk("strobe_cycles", strobe_n, MEM_LAT);
          chk(e.side ? "host_rdata" : "core_rdata", e.side ? host_rdata : core_rdata, e.rdata);
        end
        strobe_n = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Issue one access at a negedge; returns posedges until done is seen.
  task automatic txn(input bit side, input bit we, input logic [31:0] addr,
                     input logic [3:0] wb, input logic [31:0] wd, output int lat);
    bit seen;
    if (side) begin host_we = we; host_addr = addr; host_wrbits = wb; host_wdata = wd; host_req = 1'b1; end
    else      begin core_we = we; core_addr = addr; core_wrbits = wb; core_wdata = wd; core_req = 1'b1; end
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clock); lat++;
      @(negedge clock);
      seen = side ? host_done : core_done;
    end
    if (!seen) chk(side ? "host_timeout" : "core_timeout", 32'd0, 32'd1);
    if (side) host_req = 1'b0; else core_req = 1'b0;
  endtask

  int l1, l2, l3;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'hC0DE_0000 | i;
      ref_mem[i] = 32'hC0DE_0000 | i;
    end
    mem[64] = 32'hDEAD_BEEF;
    ref_mem[64] = 32'hDEAD_BEEF;

    // Reset state
    idle(3);
    chk("rst_mem_read",  {31'd0, mem_read},  32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'd0);
    chk("rst_done",      {30'd0, core_done, host_done}, 32'd0);
    chk("rst_core_rdata", core_rdata, 32'd0);
    reset = 1'b1;
    idle(2);

    // T1 core read
    push(0, 0, 32'h100, 4'h0, 32'h0);
    txn(0, 0, 32'h100, 4'h0, 32'h0, l1);
    chk("t1_latency", l1, MEM_LAT + 1);
    chk("t1_rdata", core_rdata, 32'hDEAD_BEEF);
    idle(2);

    // T2 host write; core_rdata must hold
    push(1, 1, 32'h8, 4'b0011, 32'h1234);
    txn(1, 1, 32'h8, 4'b0011, 32'h1234, l1);
    chk("t2_latency", l1, MEM_LAT + 1);
    chk("t2_core_hold", core_rdata, 32'hDEAD_BEEF);
    push(1, 0, 32'h8, 4'h0, 32'h0);
    txn(1, 0, 32'h8, 4'h0, 32'h0, l1);
    idle(2);

    // T3 tie after reset-like state: core, then host wins the renewed tie, then core
    reset = 1'b0; exp_core_rd = '0; exp_host_rd = '0;
    idle(1);
    reset = 1'b1;
    idle(1);
    push(0, 0, 32'h10, 4'h0, 32'h0);
    push(1, 0, 32'h14, 4'h0, 32'h0);
    push(0, 0, 32'h18, 4'h0, 32'h0);
    fork
      begin
        txn(0, 0, 32'h10, 4'h0, 32'h0, l1);
        txn(0, 0, 32'h18, 4'h0, 32'h0, l2);
      end
      txn(1, 0, 32'h14, 4'h0, 32'h0, l3);
    join
    chk("t3_core1_lat", l1, MEM_LAT + 1);
    chk("t3_host_lat",  l3, 2 * MEM_LAT + 3);
    chk("t3_core2_lat", l2, 2 * MEM_LAT + 4);
    idle(2);

    // T4 core_req held across three reads
    push(0, 0, 32'h40, 4'h0, 32'h0);
    core_we = 1'b0; core_addr = 32'h40; core_req = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      bit exp_done;
      @(posedge clock); @(negedge clock);
      exp_done = (c == 3) || (c == 7) || (c == 11);
      chk("t4_done", {31'd0, core_done}, {31'd0, exp_done});
      chk("t4_busy", {31'd0, core_busy}, {31'd0, !exp_done});
      if (c == 3) begin push(0, 0, 32'h44, 4'h0, 32'h0); core_addr = 32'h44; end
      if (c == 7) begin push(0, 0, 32'h48, 4'h0, 32'h0); core_addr = 32'h48; end
    end
    core_req = 1'b0;
    idle(2);

    // T5 reset during ACCESS
    core_we = 1'b0; core_addr = 32'h60; core_req = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("t5_in_access", {31'd0, mem_read}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_read_drop",  {31'd0, mem_read},  32'd0);
    chk("t5_write_drop", {31'd0, mem_write}, 32'd0);
    core_req = 1'b0;
    exp_core_rd = '0; exp_host_rd = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("t5_no_done", {30'd0, core_done, host_done}, 32'd0);
    end
    reset = 1'b1;
    idle(1);
    chk("t5_idle_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    push(0, 0, 32'h64, 4'h0, 32'h0);
    txn(0, 0, 32'h64, 4'h0, 32'h0, l1);
    chk("t5_latency", l1, MEM_LAT + 1);
    idle(2);

    // T6 host inputs change mid-ACCESS; only latched values reach memory
    push(1, 1, 32'h20, 4'b1100, 32'hAABB_CCDD);
    host_we = 1'b1; host_addr = 32'h20; host_wrbits = 4'b1100; host_wdata = 32'hAABB_CCDD;
    host_req = 1'b1;
    @(posedge clock); @(negedge clock);
    host_we = 1'b0; host_addr = 32'h3C; host_wrbits = 4'b0001; host_wdata = 32'h5555_5555;
    l1 = 0;
    while (!host_done && l1 < 40) begin @(posedge clock); @(negedge clock); l1++; end
    if (!host_done) chk("t6_timeout", 32'd0, 32'd1);
    host_req = 1'b0;
    idle(2);
    push(1, 0, 32'h20, 4'h0, 32'h0);
    txn(1, 0, 32'h20, 4'h0, 32'h0, l1);
    chk("t6_merged", host_rdata, {16'hAABB, 16'h0008});
    push(0, 0, 32'h3C, 4'h0, 32'h0);
    txn(0, 0, 32'h3C, 4'h0, 32'h0, l1);
    idle(2);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
